// File: rtl/phase_acc_bank_pkg.sv
// Shared OPL2 phase-path constants: widths, rhythm slot numbers and the
// half-unit frequency multiplier table.
package phase_acc_bank_pkg;

    localparam int NUM_OPS         = 18;
    localparam int PHASE_ACC_WIDTH = 20;
    localparam int OP_NUM_WIDTH    = 5;
    localparam int OP_HH           = 13;
    localparam int OP_TC           = 17;
    localparam int INC_PROD_WIDTH  = 22;

    // Multiplier in half-units, so code 0 (x0.5) stays an integer
    function automatic logic [4:0] mult2(input logic [3:0] mult_code);
        logic [4:0] m2;
        case (mult_code)
            4'd0:    m2 = 5'd1;
            4'd1:    m2 = 5'd2;
            4'd2:    m2 = 5'd4;
            4'd3:    m2 = 5'd6;
            4'd4:    m2 = 5'd8;
            4'd5:    m2 = 5'd10;
            4'd6:    m2 = 5'd12;
            4'd7:    m2 = 5'd14;
            4'd8:    m2 = 5'd16;
            4'd9:    m2 = 5'd18;
            4'd10:   m2 = 5'd20;
            4'd11:   m2 = 5'd20;
            4'd12:   m2 = 5'd24;
            4'd13:   m2 = 5'd24;
            4'd14:   m2 = 5'd30;
            4'd15:   m2 = 5'd30;
            default: m2 = 5'd1;
        endcase
        return m2;
    endfunction

endpackage

// File: rtl/phase_acc_bank_calc_phase_inc.sv
// Combinational per-sample phase increment from fnum, block and mult.
// Kept separate so a future vibrato path can reuse it.
module calc_phase_inc
    import phase_acc_bank_pkg::*;
(
    input  logic [9:0]                 fnum,
    input  logic [2:0]                 block,
    input  logic [3:0]                 mult,
    output logic [PHASE_ACC_WIDTH-1:0] inc
);

    logic [16:0]               shifted_s;
    logic [INC_PROD_WIDTH-1:0] product_s;

    // Octave shift, half-unit multiply, then drop the two fraction bits
    always_comb begin
        shifted_s = {7'd0, fnum} << block;
        product_s = INC_PROD_WIDTH'(shifted_s) * INC_PROD_WIDTH'(mult2(mult));
        inc       = product_s[INC_PROD_WIDTH-1:2];
    end

endmodule

// File: rtl/phase_acc_bank.sv
// Time-multiplexed bank of 18 operator phase accumulators with a two-stage
// update pipeline and rhythm-slot phase capture.
module phase_acc_bank
    import phase_acc_bank_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       slot_en,
    input  logic [OP_NUM_WIDTH-1:0]    op_num,
    input  logic [9:0]                 fnum,
    input  logic [2:0]                 block,
    input  logic [3:0]                 mult,
    input  logic                       phase_rst,
    output logic [PHASE_ACC_WIDTH-1:0] phase_acc,
    output logic                       phase_valid,
    output logic [OP_NUM_WIDTH-1:0]    phase_op,
    output logic [PHASE_ACC_WIDTH-1:0] phase_acc_13,
    output logic [PHASE_ACC_WIDTH-1:0] phase_acc_17
);

    localparam logic [OP_NUM_WIDTH-1:0] LAST_OP = OP_NUM_WIDTH'(NUM_OPS - 1);
    localparam logic [OP_NUM_WIDTH-1:0] HH_OP   = OP_NUM_WIDTH'(OP_HH);
    localparam logic [OP_NUM_WIDTH-1:0] TC_OP   = OP_NUM_WIDTH'(OP_TC);

    logic [PHASE_ACC_WIDTH-1:0] bank_r [NUM_OPS];

    logic                       accept_s;
    logic [PHASE_ACC_WIDTH-1:0] inc_s;
    logic [PHASE_ACC_WIDTH-1:0] old_s;
    logic [PHASE_ACC_WIDTH-1:0] new_s;

    logic                       s1_valid_r;
    logic                       s1_rst_r;
    logic [OP_NUM_WIDTH-1:0]    s1_op_r;
    logic [PHASE_ACC_WIDTH-1:0] s1_inc_r;
    logic [PHASE_ACC_WIDTH-1:0] s1_old_r;

    calc_phase_inc u_calc_phase_inc (
        .fnum  (fnum),
        .block (block),
        .mult  (mult),
        .inc   (inc_s)
    );

    // Accept in-range strobes; forward the value being written this edge on a same-op hit
    always_comb begin
        accept_s = 1'b0;
        old_s    = '0;
        if (slot_en && (op_num <= LAST_OP)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (!accept_s) begin
            old_s = '0;
        end else if (s1_valid_r && (s1_op_r == op_num)) begin
            old_s = new_s;
        end else begin
            old_s = bank_r[op_num];
        end
    end

    // Stage-2 accumulate: key-on clears, otherwise wrap silently
    always_comb begin
        new_s = '0;
        if (s1_rst_r) begin
            new_s = '0;
        end else begin
            new_s = s1_old_r + s1_inc_r;
        end
    end

    // Stage-1 register: operator, increment, key-on flag and old accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_rst_r   <= 1'b0;
            s1_op_r    <= '0;
            s1_inc_r   <= '0;
            s1_old_r   <= '0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_rst_r <= phase_rst;
                s1_op_r  <= op_num;
                s1_inc_r <= inc_s;
                s1_old_r <= old_s;
            end
        end
    end

    // Write-back, registered result and rhythm-slot capture
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                bank_r[i] <= '0;
            end
            phase_acc    <= '0;
            phase_valid  <= 1'b0;
            phase_op     <= '0;
            phase_acc_13 <= '0;
            phase_acc_17 <= '0;
        end else begin
            phase_valid <= s1_valid_r;
            if (s1_valid_r) begin
                bank_r[s1_op_r] <= new_s;
                phase_acc       <= new_s;
                phase_op        <= s1_op_r;
                if (s1_op_r == HH_OP) begin
                    phase_acc_13 <= new_s;
                end
                if (s1_op_r == TC_OP) begin
                    phase_acc_17 <= new_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_phase_acc_bank.sv
// Scoreboard bench for phase_acc_bank: stimulus pushes expected results from
// an arithmetic model; a negedge monitor pops and compares on phase_valid.
module tb_phase_acc_bank;

    typedef struct {
        int         op;
        logic [19:0] acc;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        slot_en;
    logic [4:0]  op_num;
    logic [9:0]  fnum;
    logic [2:0]  block;
    logic [3:0]  mult;
    logic        phase_rst;
    logic [19:0] phase_acc;
    logic        phase_valid;
    logic [4:0]  phase_op;
    logic [19:0] phase_acc_13;
    logic [19:0] phase_acc_17;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    exp_t        sbq[$];
    longint      model[18];
    logic [19:0] exp13 = 20'd0;
    logic [19:0] exp17 = 20'd0;
    int          mult2_tab[16] = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};

    phase_acc_bank dut (
        .clk          (clk),
        .rst          (rst),
        .slot_en      (slot_en),
        .op_num       (op_num),
        .fnum         (fnum),
        .block        (block),
        .mult         (mult),
        .phase_rst    (phase_rst),
        .phase_acc    (phase_acc),
        .phase_valid  (phase_valid),
        .phase_op     (phase_op),
        .phase_acc_13 (phase_acc_13),
        .phase_acc_17 (phase_acc_17)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic strobe(input int op, input int f, input int b, input int m, input bit pr);
        logic [9:0] fv;
        logic [2:0] bv;
        logic [3:0] mv;
        longint     inc;
        longint     nv;
        fv = f[9:0];
        bv = b[2:0];
        mv = m[3:0];
        @(posedge clk);
        #1;
        slot_en   = 1'b1;
        op_num    = op[4:0];
        fnum      = fv;
        block     = bv;
        mult      = mv;
        phase_rst = pr;
        if (op >= 0 && op < 18) begin
            inc = ((longint'(fv) << bv) * mult2_tab[mv]) / 4;
            nv  = pr ? 64'd0 : (model[op] + inc) % (64'd1 << 20);
            model[op] = nv;
            sbq.push_back('{op, nv[19:0], cyc});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            slot_en   = 1'b0;
            phase_rst = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        slot_en = 1'b0;
        rst     = 1'b1;
        sbq.delete();
        for (int i = 0; i < 18; i++) model[i] = 0;
        exp13 = 20'd0;
        exp17 = 20'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pop on every valid, check data, op, latency and capture registers
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (phase_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("spurious_valid", {31'd0, phase_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("phase_acc", {12'd0, phase_acc}, {12'd0, e.acc});
                    chk("phase_op", {27'd0, phase_op}, e.op);
                    chk("latency", cyc, e.cyc + 2);
                    if (e.op == 13) exp13 = e.acc;
                    if (e.op == 17) exp17 = e.acc;
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].cyc + 2) begin
                chk("missing_valid", {31'd0, phase_valid}, 32'd1);
                void'(sbq.pop_front());
            end
            chk("phase_acc_13", {12'd0, phase_acc_13}, {12'd0, exp13});
            chk("phase_acc_17", {12'd0, phase_acc_17}, {12'd0, exp17});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; slot_en = 1'b0; op_num = 5'd0; fnum = 10'd0;
        block = 3'd0; mult = 4'd0; phase_rst = 1'b0;
        for (int i = 0; i < 18; i++) model[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_phase_acc", {12'd0, phase_acc}, 32'd0);
        chk("rst_phase_valid", {31'd0, phase_valid}, 32'd0);
        chk("rst_phase_op", {27'd0, phase_op}, 32'd0);
        chk("rst_acc_13", {12'd0, phase_acc_13}, 32'd0);
        chk("rst_acc_17", {12'd0, phase_acc_17}, 32'd0);

        // Zero increment and basic accumulation
        strobe(5, 0, 0, 1, 1'b0);
        idle(4);
        for (int k = 0; k < 3; k++) begin
            strobe(0, 'h200, 4, 1, 1'b0);
            idle(17);
        end

        // Wrap and half multiplier
        strobe(2, 'h3FF, 7, 15, 1'b0);
        idle(3);
        strobe(2, 'h3FF, 7, 15, 1'b0);
        idle(3);
        strobe(3, 'h100, 0, 0, 1'b0);
        idle(3);

        // Key-on clear then resume
        for (int k = 0; k < 3; k++) begin
            strobe(1, 'h200, 4, 1, 1'b0);
            idle(3);
        end
        strobe(1, 'h200, 4, 1, 1'b1);
        idle(3);
        strobe(1, 'h200, 4, 1, 1'b0);
        idle(3);

        // Rhythm sweep: op 13 inc 0x100, op 17 inc 0x200
        for (int s = 0; s < 3; s++) begin
            for (int op = 0; op < 18; op++) begin
                if (op == 13)      strobe(op, 'h200, 0, 1, 1'b0);
                else if (op == 17) strobe(op, 'h200, 1, 1, 1'b0);
                else               strobe(op, $urandom, $urandom_range(0, 7), $urandom_range(0, 15), 1'b0);
            end
            if (s == 1) begin
                idle(4);
                chk("hh_after_sample2", {12'd0, phase_acc_13}, 32'h200);
                chk("tc_after_sample2", {12'd0, phase_acc_17}, 32'h400);
            end
        end
        idle(4);
        chk("hh_after_sample3", {12'd0, phase_acc_13}, 32'h300);
        chk("tc_after_sample3", {12'd0, phase_acc_17}, 32'h600);

        // Back-to-back bypass on op 4, then an out-of-range op
        do_reset();
        strobe(4, 'h20, 0, 1, 1'b0);
        strobe(4, 'h20, 0, 1, 1'b0);
        strobe(4, 'h20, 0, 1, 1'b0);
        strobe(20, 'h3FF, 7, 15, 1'b0);
        idle(3);
        strobe(4, 'h20, 0, 1, 1'b0);
        idle(3);

        // Reset with a strobe in flight discards it
        strobe(6, 'h155, 3, 5, 1'b0);
        do_reset();
        strobe(6, 'h155, 3, 5, 1'b0);
        idle(3);

        // Randomized traffic including invalid ops, gaps and key-on
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            strobe($urandom_range(0, 19), $urandom, $urandom_range(0, 7),
                   $urandom_range(0, 15), ($urandom_range(0, 15) == 0));
        end
        idle(1);

        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
        if (sbq.size() != 0) chk("drain", sbq.size(), 32'd0);
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
